// File: rtl/cte_stream_ctrl.sv
// Streams a pixel buffer from source memory through the colour-transform engine
// and writes each engine result to destination memory, one command at a time.
module cte_stream_ctrl #(
  parameter int AW  = 12,
  parameter int LW  = 12,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [LW-1:0] len,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          src_rd_en,
  output logic [AW-1:0] src_addr,
  input  logic [23:0]   src_rdata,
  output logic          dst_wr_en,
  output logic [AW-1:0] dst_addr,
  output logic [23:0]   dst_wdata,
  output logic          cte_op_mode,
  output logic          cte_in_en,
  output logic [7:0]    cte_yuv_in,
  output logic [23:0]   cte_rgb_in,
  input  logic          cte_busy,
  input  logic          cte_out_valid,
  input  logic [23:0]   cte_rgb_out,
  input  logic [7:0]    cte_yuv_out
);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic          mode_reg, op_mode_reg, err_reg, timeout;
  logic [LW-1:0] len_reg, fetched_reg, issued_reg, issued_inc;
  logic [LW:0]   exp_out_reg, out_cnt_reg, exp_out_next;
  logic [AW-1:0] src_base_reg, dst_base_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [23:0]   fifo_mem [2];
  logic [23:0]   head;
  logic          wr_ptr_reg, rd_ptr_reg, inflight_reg;
  logic [1:0]    fifo_cnt_reg;
  logic          dst_wr_en_reg;
  logic [AW-1:0] dst_addr_reg;
  logic [23:0]   dst_wdata_reg;
  logic          len_zero, len_bad;

  assign len_zero     = (len == '0);
  assign len_bad      = mode ? len[0] : (len[1:0] != 2'b00);
  assign exp_out_next = mode ? {len, 1'b0} : ({1'b0, len} >> 1);
  assign issued_inc   = issued_reg + LW'(1);
  assign head         = fifo_mem[rd_ptr_reg];

  // Reads in flight count against FIFO space so at most two words are ever outstanding.
  assign src_rd_en = (state_reg == RUN) && (fetched_reg < len_reg) &&
                     ((fifo_cnt_reg + {1'b0, inflight_reg}) < 2'd2);
  assign src_addr  = src_base_reg + AW'(fetched_reg);
  assign cte_in_en = (state_reg == RUN) && (fifo_cnt_reg != 2'd0) && !cte_busy;

  assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
  assign done        = (state_reg == DONE);
  assign err         = err_reg;
  assign cte_op_mode = op_mode_reg;
  assign cte_yuv_in  = head[7:0];
  assign cte_rgb_in  = head;
  assign dst_wr_en   = dst_wr_en_reg;
  assign dst_addr    = dst_addr_reg;
  assign dst_wdata   = dst_wdata_reg;

  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = (len_zero || len_bad) ? DONE : RUN;
      RUN:   if (cte_in_en && (issued_inc == len_reg)) state_next = DRAIN;
      DRAIN: begin
        if (out_cnt_reg == exp_out_reg) begin
          state_next = DONE;
        end else if (!cte_out_valid && (tmo_cnt_reg == TW'(TMO - 1))) begin
          state_next = DONE;
          timeout    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      op_mode_reg   <= 1'b0;
      err_reg       <= 1'b0;
      len_reg       <= '0;
      exp_out_reg   <= '0;
      src_base_reg  <= '0;
      dst_base_reg  <= '0;
      fetched_reg   <= '0;
      issued_reg    <= '0;
      out_cnt_reg   <= '0;
      tmo_cnt_reg   <= '0;
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      fifo_cnt_reg  <= '0;
      inflight_reg  <= 1'b0;
      dst_wr_en_reg <= 1'b0;
      dst_addr_reg  <= '0;
      dst_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      inflight_reg  <= src_rd_en;
      dst_wr_en_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (start) begin
          mode_reg     <= mode;
          op_mode_reg  <= mode;
          len_reg      <= len;
          exp_out_reg  <= exp_out_next;
          src_base_reg <= src_base;
          dst_base_reg <= dst_base;
          err_reg      <= !len_zero && len_bad;
          fetched_reg  <= '0;
          issued_reg   <= '0;
          out_cnt_reg  <= '0;
          tmo_cnt_reg  <= '0;
          wr_ptr_reg   <= 1'b0;
          rd_ptr_reg   <= 1'b0;
          fifo_cnt_reg <= '0;
        end
      end else begin
        if (src_rd_en) fetched_reg <= fetched_reg + LW'(1);
        if (inflight_reg) begin
          fifo_mem[wr_ptr_reg] <= src_rdata;
          wr_ptr_reg           <= !wr_ptr_reg;
        end
        if (cte_in_en) begin
          rd_ptr_reg <= !rd_ptr_reg;
          issued_reg <= issued_inc;
        end
        fifo_cnt_reg <= fifo_cnt_reg + {1'b0, inflight_reg} - {1'b0, cte_in_en};

        if (cte_out_valid) begin
          tmo_cnt_reg <= TW'(1);
          if (out_cnt_reg < exp_out_reg) begin
            dst_wr_en_reg <= 1'b1;
            dst_addr_reg  <= dst_base_reg + AW'(out_cnt_reg);
            dst_wdata_reg <= mode_reg ? {16'b0, cte_yuv_out} : cte_rgb_out;
            out_cnt_reg   <= out_cnt_reg + (LW + 1)'(1);
          end else begin
            err_reg <= 1'b1;
          end
        end else if (state_reg == DRAIN) begin
          tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
        // The drain timer measures idle cycles from the most recent input as well.
        if (cte_in_en) tmo_cnt_reg <= TW'(1);
        if (timeout) err_reg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cte_stream_ctrl.sv
// Scoreboard bench for cte_stream_ctrl: stimulus queues expected engine inputs,
// writes and completions; a negedge monitor pops and compares them.
module tb_cte_stream_ctrl;
  localparam int AW = 12, LW = 12, TMO = 64;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] src_base = '0, dst_base = '0;
  logic          busy, done, err, src_rd_en, dst_wr_en, cte_op_mode, cte_in_en;
  logic [AW-1:0] src_addr, dst_addr;
  logic [23:0]   src_rdata = '0, dst_wdata, cte_rgb_in, cte_rgb_out = '0;
  logic [7:0]    cte_yuv_in, cte_yuv_out = '0;
  logic          cte_busy = 1'b0, cte_out_valid = 1'b0;

  cte_stream_ctrl #(.AW(AW), .LW(LW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
    .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done), .err(err),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .cte_op_mode(cte_op_mode), .cte_in_en(cte_in_en), .cte_yuv_in(cte_yuv_in),
    .cte_rgb_in(cte_rgb_in), .cte_busy(cte_busy), .cte_out_valid(cte_out_valid),
    .cte_rgb_out(cte_rgb_out), .cte_yuv_out(cte_yuv_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_in_cyc = 0, last_wr_cyc = 0;
  int rd_total = 0, in_total = 0;
  logic        cur_mode = 1'b0, eng_mute = 1'b0, have_b = 1'b0;
  logic [7:0]  b0 = '0;
  logic [23:0] srcmem [0:4095];
  logic [23:0] exp_in [$];
  logic [35:0] exp_wr [$];
  logic        exp_done [$];
  logic [23:0] eq [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    else n_pass++;
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Source memory: data valid in the cycle after the read request.
  logic          rd_seen = 1'b0, rd_now;
  logic [AW-1:0] rd_addr_seen = '0, addr_now;
  always @(negedge clk) begin
    rd_seen      = src_rd_en;
    rd_addr_seen = src_addr;
  end
  always @(posedge clk) begin
    rd_now   = rd_seen;
    addr_now = rd_addr_seen;
    #1;
    src_rdata = rd_now ? srcmem[addr_now] : 24'hBADBAD;
  end

  // Engine model: mode 0 pairs bytes into {b0, b1, A5}; mode 1 yields two bytes per pixel.
  logic [23:0] e_eng;
  always @(negedge clk) begin
    if (reset) begin
      eq.delete();
      cte_out_valid = 1'b0;
      have_b        = 1'b0;
    end else begin
      if (eq.size() > 0) begin
        e_eng         = eq.pop_front();
        cte_out_valid = 1'b1;
        cte_rgb_out   = e_eng;
        cte_yuv_out   = e_eng[7:0];
      end else begin
        cte_out_valid = 1'b0;
      end
      if (cte_in_en && !eng_mute) begin
        if (!cte_op_mode) begin
          if (have_b) begin
            eq.push_back({b0, cte_yuv_in, 8'hA5});
            have_b = 1'b0;
          end else begin
            b0     = cte_yuv_in;
            have_b = 1'b1;
          end
        end else begin
          eq.push_back({16'hBEEF, cte_rgb_in[23:16] ^ 8'h0F});
          eq.push_back({16'hBEEF, cte_rgb_in[7:0]});
        end
      end
    end
  end

  // Monitor / scoreboard.
  logic [23:0] m_in;
  logic [35:0] m_wr;
  logic        m_done;
  always @(negedge clk) begin
    if (reset) begin
      rd_total = 0;
      in_total = 0;
    end else begin
      if (cte_in_en) begin
        in_total++;
        last_in_cyc = cyc;
        check("in_expected", exp_in.size() > 0, 1);
        if (exp_in.size() > 0) begin
          m_in = exp_in.pop_front();
          check("cte_in_data", cur_mode ? cte_rgb_in : {16'h0, cte_yuv_in}, m_in);
        end
      end
      if (src_rd_en) begin
        rd_total++;
        check("outstanding_le2", (rd_total - in_total) <= 2, 1);
      end
      if (dst_wr_en) begin
        last_wr_cyc = cyc;
        check("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          m_wr = exp_wr.pop_front();
          check("dst_write", {dst_addr, dst_wdata}, m_wr);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) begin
          m_done = exp_done.pop_front();
          check("done_err", err, m_done);
        end
        check("leftover_at_done", exp_in.size() + exp_wr.size(), 0);
      end
    end
  end

  task automatic push_wr(input int a, input logic [23:0] d);
    exp_wr.push_back({AW'(a), d});
  endtask

  task automatic start_cmd(input logic m, input int l, input int sb, input int db, input logic bad);
    @(posedge clk); #1;
    start = 1'b1; mode = m; len = LW'(l); src_base = AW'(sb); dst_base = AW'(db);
    cur_mode = m;
    have_b   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; len = '1; src_base = '1; dst_base = '1;
    @(negedge clk); #1;
    if (l == 0 || bad) begin
      check("short_done_n1", {done, busy, src_rd_en, err}, {1'b1, 1'b0, 1'b0, bad});
    end else begin
      check("startup_n1", {busy, src_rd_en, err, done, cte_op_mode}, {1'b1, 1'b1, 1'b0, 1'b0, m});
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("done_within_budget", done_cnt >= target, 1);
  endtask

  task automatic wait_inputs(input int target, input int budget);
    int k = 0;
    while (in_total < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("inputs_within_budget", in_total >= target, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int tgt, base;
    srcmem[16] = 24'd128; srcmem[17] = 24'd100; srcmem[18] = 24'd128; srcmem[19] = 24'd200;
    srcmem[32] = 24'hFFFFFF; srcmem[33] = 24'h000000;
    srcmem[48] = 24'h123456; srcmem[49] = 24'hABCDEF; srcmem[50] = 24'h00FF00; srcmem[51] = 24'h808080;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ctl", {busy, done, err, src_rd_en, dst_wr_en, cte_op_mode, cte_in_en}, 0);
    check("reset_addr", {src_addr, dst_addr}, 0);
    check("reset_data", {dst_wdata, cte_yuv_in}, 0);
    check("reset_rgb_in", cte_rgb_in, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Mode 0, four bytes -> two RGB writes
    exp_in = '{24'd128, 24'd100, 24'd128, 24'd200};
    push_wr(64, 24'h8064A5); push_wr(65, 24'h80C8A5);
    exp_done.push_back(1'b0);
    tgt = done_cnt + 1;
    start_cmd(1'b0, 4, 16, 64, 1'b0);
    @(negedge clk); #1;
    check("in_en_n2", cte_in_en, 0);
    @(negedge clk); #1;
    check("in_en_n3", cte_in_en, 1);
    wait_done(tgt, 100);
    check("done_after_last_write", done_cyc - last_wr_cyc, 1);

    // Mode 1, two pixels -> four byte writes
    exp_in = '{24'hFFFFFF, 24'h000000};
    push_wr(128, 24'h0000F0); push_wr(129, 24'h0000FF);
    push_wr(130, 24'h00000F); push_wr(131, 24'h000000);
    exp_done.push_back(1'b0);
    tgt = done_cnt + 1;
    start_cmd(1'b1, 2, 32, 128, 1'b0);
    wait_done(tgt, 100);

    // Mode 1 with engine busy for five cycles mid-stream
    exp_in = '{24'h123456, 24'hABCDEF, 24'h00FF00, 24'h808080};
    push_wr(200, 24'h00001D); push_wr(201, 24'h000056);
    push_wr(202, 24'h0000A4); push_wr(203, 24'h0000EF);
    push_wr(204, 24'h00000F); push_wr(205, 24'h000000);
    push_wr(206, 24'h00008F); push_wr(207, 24'h000080);
    exp_done.push_back(1'b0);
    tgt  = done_cnt + 1;
    base = in_total;
    start_cmd(1'b1, 4, 48, 200, 1'b0);
    wait_inputs(base + 1, 20);
    @(posedge clk); #1;
    cte_busy = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      check("in_en_while_busy", cte_in_en, 0);
    end
    @(posedge clk); #1;
    cte_busy = 1'b0;
    wait_done(tgt, 100);

    // Zero length, then bad lengths
    exp_done.push_back(1'b0);
    tgt = done_cnt + 1;
    start_cmd(1'b0, 0, 16, 64, 1'b0);
    wait_done(tgt, 10);
    exp_done.push_back(1'b1);
    tgt = done_cnt + 1;
    start_cmd(1'b0, 6, 16, 64, 1'b1);
    wait_done(tgt, 10);
    exp_done.push_back(1'b1);
    tgt = done_cnt + 1;
    start_cmd(1'b1, 3, 16, 64, 1'b1);
    wait_done(tgt, 10);

    // Engine silent: drain timeout
    eng_mute = 1'b1;
    exp_in = '{24'd128, 24'd100, 24'd128, 24'd200};
    exp_done.push_back(1'b1);
    tgt = done_cnt + 1;
    start_cmd(1'b0, 4, 16, 300, 1'b0);
    wait_done(tgt, 200);
    check("timeout_latency", done_cyc - last_in_cyc, TMO);
    check("err_sticky_after_done", err, 1);
    eng_mute = 1'b0;

    // Reset mid-run after three inputs, then a fresh command
    exp_in = '{24'h123456, 24'hABCDEF, 24'h00FF00, 24'h808080};
    push_wr(768, 24'h00001D); push_wr(769, 24'h000056);
    push_wr(770, 24'h0000A4); push_wr(771, 24'h0000EF);
    base = in_total;
    start_cmd(1'b1, 4, 48, 768, 1'b0);
    wait_inputs(base + 3, 30);
    reset = 1'b1;
    #1;
    check("midrun_reset_ctl", {busy, done, err, src_rd_en, dst_wr_en, cte_op_mode, cte_in_en}, 0);
    check("midrun_reset_addr", {src_addr, dst_addr}, 0);
    check("midrun_reset_data", {dst_wdata, cte_yuv_in}, 0);
    check("midrun_reset_rgb_in", cte_rgb_in, 0);
    exp_in.delete();
    exp_wr.delete();
    exp_done.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    exp_in = '{24'd128, 24'd100, 24'd128, 24'd200};
    push_wr(500, 24'h8064A5); push_wr(501, 24'h80C8A5);
    exp_done.push_back(1'b0);
    tgt = done_cnt + 1;
    start_cmd(1'b0, 4, 16, 500, 1'b0);
    wait_done(tgt, 100);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
